scalar_reg_file_sb: RTL and testbench

- Parametrised scalar register file with two synchronous read ports and one write port.
- Write-first bypass from write port to read ports.
- Per-register busy scoreboard for in-flight producers such as loads and multi-cycle ALU ops.
- Sits between decode (reads, reservations) and writeback (writes, busy clear); decode uses the busy outputs to raise hazard stalls.

---
 rtl/srf_pkg.sv | 11 +
 rtl/srf_scoreboard.sv | 40 ++++
 rtl/scalar_reg_file_sb.sv | 84 ++++++++
 tb/tb_scalar_reg_file_sb.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/srf_pkg.sv
// Shared defaults and types for the scalar register file with busy scoreboard.
package srf_pkg;

  localparam int SRF_DATA_W = 16;
  localparam int SRF_DEPTH  = 16;
  localparam int SRF_ADDR_W = $clog2(SRF_DEPTH);

  typedef logic [SRF_ADDR_W-1:0] reg_addr_t;
  typedef logic [SRF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/srf_scoreboard.sv
// Per-register busy bits: reservation at issue sets, writeback clears, set wins on a tie.
module srf_scoreboard
  import srf_pkg::*;
#(
  parameter  int DEPTH  = SRF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_dst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_dst,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic              busy_1,
  output logic              busy_2,
  output logic [DEPTH-1:0]  busy_vec
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wr_dst] = 1'b0;
    if (rsv_en) busy_d[rsv_dst] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // A register completing this cycle is forwarded by the bypass, so it need not stall decode.
  assign busy_1   = busy_q[rd_addr_1] & ~(wr_en & (wr_dst == rd_addr_1));
  assign busy_2   = busy_q[rd_addr_2] & ~(wr_en & (wr_dst == rd_addr_2));
  assign busy_vec = busy_q;

endmodule

// File: rtl/scalar_reg_file_sb.sv
// Scalar register file: 2 registered read ports, 1 write port with write-first bypass, busy scoreboard.
// Define SRF_ZERO_REG_EN to hard-wire register 0 to zero (writes and reservations to it are dropped).
module scalar_reg_file_sb
  import srf_pkg::*;
#(
  parameter  int DATA_W = SRF_DATA_W,
  parameter  int DEPTH  = SRF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_2,
  output logic              busy_1,
  output logic              busy_2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_dst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_dst,
  output logic [DEPTH-1:0]  busy_vec
);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] data_1_q, data_1_d;
  logic [DATA_W-1:0] data_2_q, data_2_d;
  logic              wr_eff;
  logic              rsv_eff;

`ifdef SRF_ZERO_REG_EN
  // Register 0 is never written, so its reset value of zero is what every read sees.
  assign wr_eff  = wr_en  & (wr_dst  != '0);
  assign rsv_eff = rsv_en & (rsv_dst != '0);
`else
  assign wr_eff  = wr_en;
  assign rsv_eff = rsv_en;
`endif

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (!rst_n)                                  regs_q[gi] <= '0;
        else if (wr_eff && (wr_dst == ADDR_W'(gi)))  regs_q[gi] <= wr_data;
      end
    end
  endgenerate

  always_comb begin
    data_1_d = (wr_eff && (wr_dst == rd_addr_1)) ? wr_data : regs_q[rd_addr_1];
    data_2_d = (wr_eff && (wr_dst == rd_addr_2)) ? wr_data : regs_q[rd_addr_2];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_1_q <= '0;
      data_2_q <= '0;
    end else begin
      data_1_q <= data_1_d;
      data_2_q <= data_2_d;
    end
  end

  assign data_1 = data_1_q;
  assign data_2 = data_2_q;

  srf_scoreboard #(
    .DEPTH(DEPTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .rsv_en   (rsv_eff),
    .rsv_dst  (rsv_dst),
    .wr_en    (wr_eff),
    .wr_dst   (wr_dst),
    .rd_addr_1(rd_addr_1),
    .rd_addr_2(rd_addr_2),
    .busy_1   (busy_1),
    .busy_2   (busy_2),
    .busy_vec (busy_vec)
  );

endmodule

// File: tb/tb_scalar_reg_file_sb.sv
// Directed bench for scalar_reg_file_sb; honours SRF_ZERO_REG_EN for the register-0 expectations.
module tb_scalar_reg_file_sb;
  import srf_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  reg_addr_t rd_addr_1, rd_addr_2, wr_dst, rsv_dst;
  reg_data_t data_1, data_2, wr_data;
  logic      busy_1, busy_2, wr_en, rsv_en;
  logic [SRF_DEPTH-1:0] busy_vec;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SRF_ZERO_REG_EN
  localparam logic [15:0] R0_EXP   = 16'h0000;
  localparam logic        R0_BUSY  = 1'b0;
`else
  localparam logic [15:0] R0_EXP   = 16'hFFFF;
  localparam logic        R0_BUSY  = 1'b1;
`endif

  always #5 clk = ~clk;

  scalar_reg_file_sb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr_1(rd_addr_1),
    .rd_addr_2(rd_addr_2),
    .data_1   (data_1),
    .data_2   (data_2),
    .busy_1   (busy_1),
    .busy_2   (busy_2),
    .wr_en    (wr_en),
    .wr_dst   (wr_dst),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_dst  (rsv_dst),
    .busy_vec (busy_vec)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-14s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wr(input int dst, input logic [15:0] d);
    wr_en = 1'b1; wr_dst = reg_addr_t'(dst); wr_data = d;
  endtask

  task automatic rsv(input int dst);
    rsv_en = 1'b1; rsv_dst = reg_addr_t'(dst);
  endtask

  task automatic rd(input int a1, input int a2);
    rd_addr_1 = reg_addr_t'(a1); rd_addr_2 = reg_addr_t'(a2);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
    wr_dst = '0; wr_data = '0; rsv_dst = '0; rd(0, 0);
    step(); step();
    chk("rst_data_1", 32'(data_1), 32'h0);
    chk("rst_data_2", 32'(data_2), 32'h0);
    chk("rst_busy_vec", 32'(busy_vec), 32'h0);
    rst_n = 1'b1;

    // basic write then read
    wr(3, 16'h1234); step();
    wr(7, 16'hBEEF); step();
    wr_en = 1'b0; rd(3, 7); step();
    chk("rd_r3", 32'(data_1), 32'h1234);
    chk("rd_r7", 32'(data_2), 32'hBEEF);
    rd(5, 7); step();
    chk("rd_r5", 32'(data_1), 32'h0000);

    // write-first bypass on both ports
    wr(4, 16'h0001); step();
    wr(4, 16'hAAAA); rd(4, 4); step();
    chk("byp_data_1", 32'(data_1), 32'hAAAA);
    chk("byp_data_2", 32'(data_2), 32'hAAAA);
    wr_en = 1'b0; step();
    chk("rd_r4_after", 32'(data_1), 32'hAAAA);

    // reserve then complete r9
    rsv(9); step();
    rsv_en = 1'b0; rd(9, 4); #1;
    chk("busy_vec9_set", 32'(busy_vec[9]), 32'h1);
    chk("busy_1_r9", 32'(busy_1), 32'h1);
    wr(9, 16'h0F0F); #1;
    chk("busy_1_wrcyc", 32'(busy_1), 32'h0);
    step();
    chk("busy_vec9_clr", 32'(busy_vec[9]), 32'h0);
    wr_en = 1'b0; step();
    chk("rd_r9", 32'(data_1), 32'h0F0F);

    // same-index set/clear: set wins, data still written
    rsv(2); wr(2, 16'h2222); step();
    chk("busy_vec2_tie", 32'(busy_vec[2]), 32'h1);
    wr_en = 1'b0; rsv(6); step();
    rsv(5); wr(6, 16'h6666); step();
    chk("busy_vec5_set", 32'(busy_vec[5]), 32'h1);
    chk("busy_vec6_clr", 32'(busy_vec[6]), 32'h0);
    chk("busy_vec_all", 32'(busy_vec), 32'h0024);
    rsv(5); wr_en = 1'b0; rd(2, 5); step();
    chk("rd_r2", 32'(data_1), 32'h2222);
    chk("busy_vec5_rersv", 32'(busy_vec[5]), 32'h1);
    rsv_en = 1'b0; #1;
    chk("busy_2_r5", 32'(busy_2), 32'h1);
    // write to a non-busy register leaves its bit clear
    wr(11, 16'h1111); step();
    chk("busy_vec11", 32'(busy_vec[11]), 32'h0);

    // register 0 behaviour depends on the build
    wr(0, 16'hFFFF); rd(0, 0); step();
    chk("r0_bypass", 32'(data_1), 32'(R0_EXP));
    wr_en = 1'b0; step();
    chk("r0_read", 32'(data_2), 32'(R0_EXP));
    rsv(0); step();
    rsv_en = 1'b0; #1;
    chk("busy_vec0", 32'(busy_vec[0]), 32'(R0_BUSY));
    chk("busy_1_r0", 32'(busy_1), 32'(R0_BUSY));

    // reset mid-operation, with a write and reservation colliding with it
    rsv(1); step();
    rsv(2); wr(3, 16'h5555); step();
    chk("busy_pre_rst", 32'(busy_vec[2:1]), 32'h3);
    rst_n = 1'b0; wr(8, 16'h8888); rsv(8); rd(3, 8); step();
    chk("midrst_busy", 32'(busy_vec), 32'h0);
    chk("midrst_data_1", 32'(data_1), 32'h0);
    chk("midrst_data_2", 32'(data_2), 32'h0);
    rst_n = 1'b1; wr_en = 1'b0; rsv_en = 1'b0; step();
    chk("post_rst_r3", 32'(data_1), 32'h0);
    chk("post_rst_r8", 32'(data_2), 32'h0);
    chk("post_rst_busy", 32'(busy_vec), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
